booth_mul_if: RTL and testbench
===============================

// Module: booth_mul_if
// PURPOSE
//  Handshake front/back end for the sequential Booth multiplier (control unit + datapath).
//  Accepts an operand pair on a valid/ready port and drives the multiplier's M and Q load
//  buses, then issues a one-cycle start pulse.
//  Waits for fin, captures the 2*WIDTH product, and holds it on a valid/ready result port.
//  A timeout guards against a missing fin.
// PARAMETERS
//  WIDTH    7   operand width in bits (two's complement); the product is 2*WIDTH bits
//  TIMEOUT  31  number of WAIT cycles without fin before err_timeout is raised (must be >= 1)
// PORTS
//  clk            in   1        single clock, all state updates on the rising edge
//  reset          in   1        synchronous, active-high; sampled on the rising edge of clk
//  in_valid       in   1        operand pair present
//  in_ready       out  1        block can accept an operand pair
//  in_m           in   WIDTH    multiplicand
//  in_q           in   WIDTH    multiplier
//  mul_start      out  1        start pulse to the Booth control unit
//  mul_m          out  WIDTH    multiplicand bus to the datapath M register
//  mul_q          out  WIDTH    multiplier bus to the datapath Q register
//  mul_fin        in   1        done flag from the Booth control unit
//  mul_product    in   2*WIDTH  {A,Q} product bus from the datapath
//  out_valid      out  1        result present
//  out_ready      in   1        consumer accepts the result
//  out_product    out  2*WIDTH  captured product
//  err_timeout    out  1        last operation timed out; out_product is 0 for that result
//  busy           out  1        high in every state except IDLE
// BEHAVIOUR
//  States (2-bit register): IDLE, LAUNCH, WAIT, DONE.
//  Reset (reset=1 at a clock edge) sets:
//   - state=IDLE, wait counter=0
//   - mul_start=0, mul_m=0, mul_q=0
//   - out_valid=0, out_product=0, err_timeout=0
//  in_ready is combinational: 1 only when state==IDLE and reset==0.
//  Reset mid-operation abandons the operation and any pending result; nothing is reissued.
//  IDLE:
//   - in_valid & in_ready: register in_m->mul_m, in_q->mul_q, clear err_timeout, next LAUNCH.
//   - Otherwise stay.
//  LAUNCH:
//   - mul_start=1 for exactly this one cycle (decoded from the registered state, glitch-free).
//   - Clear the counter; next WAIT.
//   - mul_m and mul_q hold their values from LAUNCH until the block leaves WAIT.
//  WAIT:
//   - mul_start=0; counter += 1 each cycle.
//   - mul_fin=1: out_product<=mul_product, out_valid<=1, next DONE.
//   - Else if counter==TIMEOUT-1: out_product<=0, err_timeout<=1, out_valid<=1, next DONE.
//   - mul_fin and timeout in the same cycle: fin wins, err_timeout stays 0.
//  DONE:
//   - out_valid and out_product held stable.
//   - out_valid & out_ready: out_valid<=0, next IDLE.
//   - Earliest next acceptance is the cycle after the handoff; no overlap of operations.
//  mul_fin is ignored in IDLE, LAUNCH and DONE; stale fin never produces a result.
//  Counter width is $clog2(TIMEOUT+1); it never wraps, because it is cleared in LAUNCH.
//  The product is passed through unmodified; no sign handling is done in this block.
//  err_timeout stays valid until the next operand acceptance.
//  Latency (accept edge to out_valid) is 2 + N cycles, where N = WAIT cycles until fin.
//  With the existing control unit, N = 15 (14 state steps after start drops, plus capture).
// TESTING
//  1. in_m=5, in_q=3, model fin after 15 WAIT cycles with product 15
//     -> mul_start high 1 cycle, out_valid high, out_product=14'd15, err_timeout=0.
//  2. in_m=-4 (7'h7C), in_q=6, product bus 14'h3FE8
//     -> out_product=14'h3FE8 (-24); hold out_ready=0 for 10 cycles -> out_valid/out_product stable.
//  3. mul_fin never asserted -> after 31 WAIT cycles: out_valid=1, out_product=0, err_timeout=1;
//     next accepted pair clears err_timeout.
//  4. reset pulsed in WAIT cycle 5 -> next cycle state=IDLE, in_ready=1, out_valid=0;
//     a late mul_fin produces no result.
//  5. mul_fin held high in IDLE and LAUNCH -> no capture; result only on fin seen in WAIT.
//  6. in_valid held high with back-to-back pairs (1*1, 2*2)
//     -> exactly two mul_start pulses; second accept only after first out handshake.

Source files
------------

// File: rtl/booth_mul_if.sv
// Handshake front/back end for the sequential Booth multiplier: loads operands, pulses start,
// waits for fin (with timeout) and presents the captured product on a valid/ready port.
module booth_mul_if #(
  parameter int WIDTH   = 7,
  parameter int TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_q,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_m,
  output logic [WIDTH-1:0]     mul_q,
  input  logic                 mul_fin,
  input  logic [2*WIDTH-1:0]   mul_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 err_timeout,
  output logic                 busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   wait_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; fin outranks the timeout when both land in the same WAIT cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_next = S_LAUNCH;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_LAUNCH: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mul_fin || (wait_cnt == CNT_LAST)) begin
          state_next = S_DONE;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_DONE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state only, so mul_start cannot glitch.
  always_comb begin
    in_ready  = 1'b0;
    mul_start = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = ~reset;
        busy     = 1'b0;
      end
      S_LAUNCH: begin
        mul_start = 1'b1;
      end
      S_WAIT: begin
        mul_start = 1'b0;
      end
      S_DONE: begin
        mul_start = 1'b0;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Operand buses, wait counter and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= {CW{1'b0}};
      mul_m       <= {WIDTH{1'b0}};
      mul_q       <= {WIDTH{1'b0}};
      out_valid   <= 1'b0;
      out_product <= {(2*WIDTH){1'b0}};
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mul_m       <= in_m;
            mul_q       <= in_q;
            err_timeout <= 1'b0;
          end
        end
        S_LAUNCH: begin
          wait_cnt <= {CW{1'b0}};
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (mul_fin) begin
            out_product <= mul_product;
            out_valid   <= 1'b1;
          end else if (wait_cnt == CNT_LAST) begin
            out_product <= {(2*WIDTH){1'b0}};
            err_timeout <= 1'b1;
            out_valid   <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_if.sv
// Self-checking bench for booth_mul_if: a behavioural multiplier stub answers each start pulse
// with the signed product after a chosen number of WAIT cycles; table, random and corner tests.
module tb_booth_mul_if;

  localparam int W = 7;
  localparam int T = 31;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_m;
  logic [W-1:0]    in_q;
  logic            mul_start;
  logic [W-1:0]    mul_m;
  logic [W-1:0]    mul_q;
  logic            mul_fin;
  logic [2*W-1:0]  mul_product;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_product;
  logic            err_timeout;
  logic            busy;

  logic            stub_fin;
  logic            fin_force;
  int              stub_delay;
  int              start_cnt;
  int              n_tests;
  int              n_fail;

  assign mul_fin = stub_fin | fin_force;

  booth_mul_if #(.WIDTH(W), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_m(in_m), .in_q(in_q), .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
    .mul_fin(mul_fin), .mul_product(mul_product), .out_valid(out_valid),
    .out_ready(out_ready), .out_product(out_product), .err_timeout(err_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_product(logic [W-1:0] a, logic [W-1:0] b);
    int x;
    int y;
    int p;
    x = $signed(a);
    y = $signed(b);
    p = x * y;
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Multiplier stub: fin in WAIT cycle stub_delay after the start pulse (0 = never).
  initial begin
    int  st_cnt;
    int  st_delay;
    bit  st_active;
    logic [2*W-1:0] st_p;
    stub_fin = 1'b0;
    mul_product = 14'h2AAA;
    st_active = 1'b0;
    st_cnt = 0;
    st_delay = 0;
    st_p = '0;
    forever begin
      @(negedge clk);
      stub_fin = 1'b0;
      mul_product = 14'h2AAA;
      if (mul_start) begin
        st_active = 1'b1;
        st_cnt = 0;
        st_delay = stub_delay;
        st_p = ref_product(mul_m, mul_q);
      end else if (st_active) begin
        st_cnt++;
        if (st_cnt == st_delay) begin
          stub_fin = 1'b1;
          mul_product = st_p;
          st_active = 1'b0;
        end else if (st_cnt > 200) begin
          st_active = 1'b0;
        end
      end
    end
  end

  initial begin
    start_cnt = 0;
    forever begin
      @(negedge clk);
      if (mul_start) start_cnt++;
    end
  end

  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input int delay,
                       input logic [2*W-1:0] exp_p, input logic exp_err, input int hold,
                       input bit force_fin, input string name);
    int cyc;
    int s0;
    int exp_lat;
    bit stable;
    logic [2*W-1:0] held;
    s0 = start_cnt;
    exp_lat = 2 + (exp_err ? T : delay);
    @(negedge clk);
    stub_delay = delay;
    fin_force = force_fin;
    in_m = m;
    in_q = q;
    in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) check({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({name, "_err_cleared"}, 32'(err_timeout), 32'd0);
      if (cyc == 2) fin_force = 1'b0;
    end while (!out_valid && cyc < 100);
    check({name, "_out_valid"}, 32'(out_valid), 32'd1);
    check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({name, "_product"}, 32'(out_product), 32'(exp_p));
    check({name, "_err"}, 32'(err_timeout), 32'(exp_err));
    check({name, "_starts"}, 32'(start_cnt - s0), 32'd1);
    if (hold > 0) begin
      stable = 1'b1;
      held = out_product;
      fin_force = force_fin;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!out_valid || out_product !== held) stable = 1'b0;
      end
      fin_force = 1'b0;
      check({name, "_hold_stable"}, 32'(stable), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({name, "_handoff"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
    check({name, "_err_kept"}, 32'(err_timeout), 32'(exp_err));
  endtask

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    int             delay;
    logic [2*W-1:0] p;
    logic           err;
    int             hold;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cyc;
    int s0;
    bit ok;
    logic [W-1:0] rm;
    logic [W-1:0] rq;
    int rd;
    int rsel;
    logic rerr;

    vecs[0] = '{7'd5,  7'd3,  15, 14'h000F, 1'b0, 0};
    vecs[1] = '{7'h7C, 7'd6,  15, 14'h3FE8, 1'b0, 10};
    vecs[2] = '{7'h0A, 7'h0B, 0,  14'h0000, 1'b1, 1};
    vecs[3] = '{7'd7,  7'd7,  1,  14'h0031, 1'b0, 0};
    vecs[4] = '{7'h40, 7'h40, 31, 14'h1000, 1'b0, 0};
    vecs[5] = '{7'h40, 7'h3F, 32, 14'h0000, 1'b1, 2};
    vecs[6] = '{7'h3F, 7'h3F, 30, 14'h0F81, 1'b0, 0};
    vecs[7] = '{7'h40, 7'h3F, 2,  14'h3040, 1'b0, 0};
    vecs[8] = '{7'h7F, 7'h7F, 15, 14'h0001, 1'b0, 0};
    vecs[9] = '{7'h00, 7'h55, 5,  14'h0000, 1'b0, 0};

    n_tests = 0;
    n_fail = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_m = '0;
    in_q = '0;
    out_ready = 1'b0;
    fin_force = 1'b0;
    stub_delay = 15;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready_low", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_flags", {28'd0, out_valid, err_timeout, mul_start, busy}, 32'd0);
    check("reset_buses", {4'd0, out_product, mul_m, mul_q}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].m, vecs[i].q, vecs[i].delay, vecs[i].p, vecs[i].err,
            vecs[i].hold, 1'b0, $sformatf("vec%0d", i));
    end

    // fin held high in IDLE, LAUNCH and DONE: only the fin seen in WAIT counts
    do_op(7'd3, 7'h7E, 15, 14'h3FFA, 1'b0, 2, 1'b1, "stale_fin");

    // reset in WAIT cycle 5 abandons the operation; the late fin is ignored
    @(negedge clk);
    stub_delay = 15;
    in_m = 7'd9;
    in_q = 7'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_state", {29'd0, in_ready, out_valid, busy}, 32'b100);
    ok = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid || busy) ok = 1'b0;
    end
    check("abort_no_late_result", 32'(ok), 32'd1);

    // back-to-back pairs with in_valid held high
    @(negedge clk);
    s0 = start_cnt;
    stub_delay = 15;
    in_m = 7'd1;
    in_q = 7'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_m = 7'd2;
    in_q = 7'd2;
    ok = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (in_ready) ok = 1'b0;
    end while (!out_valid && cyc < 100);
    check("b2b_first_product", 32'(out_product), 32'd1);
    repeat (3) begin
      @(negedge clk);
      if (in_ready) ok = 1'b0;
    end
    check("b2b_no_overlap", 32'(ok), 32'd1);
    check("b2b_one_start", 32'(start_cnt - s0), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("b2b_ready_after_handoff", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 100);
    check("b2b_second_product", 32'(out_product), 32'd4);
    check("b2b_two_starts", 32'(start_cnt - s0), 32'd2);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // randomized operations against the arithmetic reference
    for (int i = 0; i < 30; i++) begin
      rm = W'($urandom_range(0, 127));
      rq = W'($urandom_range(0, 127));
      rsel = $urandom_range(0, 9);
      if (rsel == 0) rd = 0;
      else if (rsel == 1) rd = T + $urandom_range(1, 5);
      else rd = $urandom_range(1, T);
      rerr = (rd < 1 || rd > T);
      do_op(rm, rq, rd, rerr ? 14'h0000 : ref_product(rm, rq), rerr,
            $urandom_range(0, 3), 1'b0, $sformatf("rand%0d", i));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
